// File: rtl/sparse_weight_encoder.sv
// sparse_weight_encoder
//   Streaming 2:4 structured-sparsity encoder. Dense int8 rows of four weights
//   are encoded into two-value/two-index packets, collected into a tile of
//   N_ROWS packets and handed to the PE array with a valid/ready handshake.
//   Rows with more than two nonzeros are pruned to their two largest-magnitude
//   weights and flagged on the sticky prune_err output.
//
//   Optional build macro: SPARSE_ENC_STATS_EN
//     defined   -> adds the 16-bit saturating pruned_rows counter and port
//     undefined -> no counter, no port; prune_err is unchanged
//
//   The packet type lives in sparse_pkg (declared first in this file) so the
//   PE array and the encoder share one definition.

package sparse_pkg;

    localparam int VAL_BITS = 8;

    // One encoded row: two kept weights and their positions, idx[0] < idx[1].
    typedef struct packed {
        logic [0:1][VAL_BITS-1:0] vals;
        logic [0:1][1:0]          idx;
    } sparse_packet_t;

endpackage : sparse_pkg


module sparse_weight_encoder #(
    parameter int N_ROWS = 4,
    parameter int W_BITS = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [W_BITS-1:0]   in_row [0:3],
    output logic                       out_valid,
    input  logic                       out_ready,
    output sparse_pkg::sparse_packet_t w_rows [0:N_ROWS-1],
    output logic                       prune_err,
    input  logic                       err_clr
`ifdef SPARSE_ENC_STATS_EN
    ,
    output logic [15:0]                pruned_rows
`endif
);

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } state_t;

    // Slot index of the final row of a tile, in the width of row_cnt.
    localparam logic [1:0] LAST_SLOT = 2'(N_ROWS - 1);

    state_t       state;
    state_t       state_next;
    logic [1:0]   row_cnt;
    logic         accept;
    logic         last_row;

    // Encoder datapath signals.
    logic [W_BITS:0]            mag [0:3];
    logic [2:0]                 nz;
    logic [1:0]                 first_pos;
    logic [1:0]                 second_pos;
    logic [1:0]                 lo_pos;
    logic [1:0]                 hi_pos;
    logic                       prune;
    sparse_pkg::sparse_packet_t enc_pkt;

    // A row moves only while collecting; in_ready never looks at in_valid.
    assign accept   = in_valid && (state == COLLECT);
    assign last_row = (row_cnt == LAST_SLOT);

    // ------------------------------------------------------------------
    // Row encoder
    // ------------------------------------------------------------------

    // Unsigned magnitude per weight, one bit wider so that -128 maps to 128.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            mag[i] = in_row[i][W_BITS-1] ? ({1'b0, ~in_row[i]} + 1'b1)
                                         : {1'b0, in_row[i]};
        end
    end

    // Pick the two largest magnitudes (ties to the lower position) and count
    // nonzeros. Zeros have magnitude 0, so for rows with two or fewer nonzeros
    // the same search yields the nonzeros plus the lowest free zero positions,
    // which is exactly the padding rule for sparse rows.
    always_comb begin
        // NOTE: every variable assigned in this block gets a value up front so
        // that no path leaves it holding state, which would infer a latch.
        nz         = '0;
        first_pos  = 2'd0;
        second_pos = 2'd1;

        for (int i = 0; i < 4; i++) begin
            if (in_row[i] != '0) begin
                nz = nz + 3'd1;
            end
        end

        // Strictly-greater scan in ascending order keeps the lowest index on ties.
        for (int i = 1; i < 4; i++) begin
            if (mag[i] > mag[first_pos]) begin
                first_pos = 2'(i);
            end
        end

        second_pos = (first_pos == 2'd0) ? 2'd1 : 2'd0;
        for (int i = 0; i < 4; i++) begin
            if ((2'(i) != first_pos) && (mag[i] > mag[second_pos])) begin
                second_pos = 2'(i);
            end
        end
    end

    // Order the two kept positions and copy the weights bit-exact.
    always_comb begin
        lo_pos          = (first_pos < second_pos) ? first_pos  : second_pos;
        hi_pos          = (first_pos < second_pos) ? second_pos : first_pos;
        prune           = (nz > 3'd2);
        enc_pkt         = '0;
        enc_pkt.vals[0] = in_row[lo_pos];
        enc_pkt.vals[1] = in_row[hi_pos];
        enc_pkt.idx[0]  = lo_pos;
        enc_pkt.idx[1]  = hi_pos;
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake decode; both handshake outputs come from state only.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;

        case (state)
            COLLECT: begin
                in_ready = 1'b1;
                if (accept && last_row) begin
                    state_next = EMIT;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = COLLECT;
                end
            end
            default: begin
                state_next = COLLECT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Tile buffer and row counter
    // ------------------------------------------------------------------

    // Write each accepted row into its slot; w_rows is this register directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt <= '0;
            // NOTE: the tile is small and its contents are visible on w_rows,
            // so it is reset to a defined all-zero state rather than left as X.
            for (int i = 0; i < N_ROWS; i++) begin
                w_rows[i] <= '0;
            end
        end else if (accept) begin
            w_rows[row_cnt] <= enc_pkt;
            row_cnt         <= last_row ? 2'd0 : (row_cnt + 2'd1);
        end
    end

    // ------------------------------------------------------------------
    // Error reporting
    // ------------------------------------------------------------------

    // Sticky prune flag; a prune event in the same cycle as err_clr wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prune_err <= 1'b0;
        end else if (accept && prune) begin
            prune_err <= 1'b1;
        end else if (err_clr) begin
            prune_err <= 1'b0;
        end
    end

`ifdef SPARSE_ENC_STATS_EN
    // Count after a same-cycle clear, so clear plus event leaves 1.
    logic [15:0] cnt_base;
    assign cnt_base = err_clr ? 16'd0 : pruned_rows;

    // Saturating count of pruned rows, holding at 0xFFFF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pruned_rows <= '0;
        end else if (accept && prune && (cnt_base != 16'hFFFF)) begin
            pruned_rows <= cnt_base + 16'd1;
        end else begin
            pruned_rows <= cnt_base;
        end
    end
`endif

endmodule : sparse_weight_encoder

// File: tb/tb_sparse_weight_encoder.sv
// tb_sparse_weight_encoder
//   Scoreboard bench for sparse_weight_encoder. The stimulus process encodes
//   every accepted row with a reference model and pushes whole expected tiles
//   into a queue; an independent monitor pops and compares a tile whenever the
//   DUT completes an output handshake. Define SPARSE_ENC_STATS_EN to also
//   cover the pruned_rows counter.

module tb_sparse_weight_encoder;

    typedef sparse_pkg::sparse_packet_t [0:3] tile_t;

    logic                       clk;
    logic                       rst_n;
    logic                       in_valid;
    logic                       in_ready;
    logic signed [7:0]          in_row [0:3];
    logic                       out_valid;
    logic                       out_ready;
    sparse_pkg::sparse_packet_t w_rows [0:3];
    logic                       prune_err;
    logic                       err_clr;
`ifdef SPARSE_ENC_STATS_EN
    logic [15:0]                pruned_rows;
`endif

    sparse_weight_encoder #(
        .N_ROWS(4),
        .W_BITS(8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_row     (in_row),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .w_rows     (w_rows),
        .prune_err  (prune_err),
        .err_clr    (err_clr)
`ifdef SPARSE_ENC_STATS_EN
        ,
        .pruned_rows(pruned_rows)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Scoreboard state.
    sparse_pkg::sparse_packet_t rows_q [$];
    tile_t                      exp_q  [$];
    bit                         exp_err;
    int                         exp_cnt;
    bit                         rand_ready;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int count_nz(input int w[4]);
        int n = 0;
        for (int i = 0; i < 4; i++) if (w[i] != 0) n++;
        return n;
    endfunction

    function automatic int abs_i(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference encoder written straight from the 2:4 rules.
    function automatic sparse_pkg::sparse_packet_t ref_encode(input int w[4]);
        sparse_pkg::sparse_packet_t p;
        int  sel[$];
        bit  used[4];
        if (count_nz(w) <= 2) begin
            for (int i = 0; i < 4; i++) if (w[i] != 0) sel.push_back(i);
            for (int i = 0; i < 4; i++) if (w[i] == 0 && sel.size() < 2) sel.push_back(i);
        end else begin
            for (int k = 0; k < 2; k++) begin
                int best = -1;
                for (int i = 0; i < 4; i++) begin
                    if (!used[i] && (best < 0 || abs_i(w[i]) > abs_i(w[best]))) best = i;
                end
                used[best] = 1'b1;
                sel.push_back(best);
            end
        end
        sel.sort();
        p = '0;
        for (int k = 0; k < 2; k++) begin
            p.vals[k] = 8'(w[sel[k]]);
            p.idx[k]  = 2'(sel[k]);
        end
        return p;
    endfunction

    function automatic void model_accept(input int w[4], input bit clr);
        tile_t t;
        rows_q.push_back(ref_encode(w));
        if (clr) begin
            exp_err = 1'b0;
            exp_cnt = 0;
        end
        if (count_nz(w) > 2) begin
            exp_err = 1'b1;
            if (exp_cnt < 65535) exp_cnt++;
        end
        if (rows_q.size() == 4) begin
            for (int k = 0; k < 4; k++) t[k] = rows_q[k];
            exp_q.push_back(t);
            rows_q.delete();
        end
    endfunction

    // Present one row starting at a negedge; returns at the negedge after acceptance.
    task automatic send_row(input int a, input int b, input int c, input int d, input bit clr);
        int w[4];
        int guard;
        w = '{a, b, c, d};
        for (int i = 0; i < 4; i++) in_row[i] = 8'(w[i]);
        in_valid = 1'b1;
        err_clr  = clr;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            guard++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            err_clr  = 1'b0;
            return;
        end
        model_accept(w, clr);
        @(negedge clk);
        in_valid = 1'b0;
        err_clr  = 1'b0;
        check("prune_err", 32'(prune_err), 32'(exp_err));
`ifdef SPARSE_ENC_STATS_EN
        check("pruned_rows", 32'(pruned_rows), 32'(exp_cnt));
`endif
    endtask

    task automatic check_tile_zero(input string name);
        for (int k = 0; k < 4; k++) check(name, 32'(w_rows[k]), 32'd0);
    endtask

    // Monitor: compare each handshaken tile against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_tile", 32'd1, 32'd0);
                end else begin
                    tile_t t;
                    t = exp_q.pop_front();
                    for (int k = 0; k < 4; k++) begin
                        check($sformatf("tile_slot%0d", k), 32'(w_rows[k]), 32'(t[k]));
                    end
                end
            end
        end
    end

    initial begin
        int guard;
        int w[4];
        tile_t head;

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        err_clr    = 1'b0;
        rand_ready = 1'b0;
        exp_err    = 1'b0;
        exp_cnt    = 0;
        for (int i = 0; i < 4; i++) in_row[i] = '0;

        // Reset state.
        #17;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_prune_err", 32'(prune_err), 32'd0);
        check_tile_zero("rst_tile");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_rst", 32'(in_ready), 32'd1);

        // Basic tile with out_ready held high.
        send_row(0, 5, 0, -3, 1'b0);
        send_row(7, 0, 0, 0, 1'b0);
        send_row(0, 0, 0, 0, 1'b0);
        send_row(1, 2, 0, 0, 1'b0);
        check("ov_rise", 32'(out_valid), 32'd1);
        check("ir_low_in_emit", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("ov_one_cycle", 32'(out_valid), 32'd0);
        check("ir_back", 32'(in_ready), 32'd1);

        // Pruning, tie case and backpressure.
        out_ready = 1'b0;
        send_row(-128, 3, 127, -4, 1'b0);
        send_row(4, -4, 4, 0, 1'b0);
        send_row(0, 0, 9, 0, 1'b0);
        send_row(-1, 0, 0, -2, 1'b0);
        head = exp_q[0];
        for (int c = 0; c < 10; c++) begin
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            for (int k = 0; k < 4; k++) check("bp_stable", 32'(w_rows[k]), 32'(head[k]));
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ir", 32'(in_ready), 32'd1);
        check("bp_release_ov", 32'(out_valid), 32'd0);

        // err_clr alone, then err_clr together with a prune event.
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        exp_err = 1'b0;
        exp_cnt = 0;
        check("clr_prune_err", 32'(prune_err), 32'd0);
`ifdef SPARSE_ENC_STATS_EN
        check("clr_pruned_rows", 32'(pruned_rows), 32'd0);
`endif
        send_row(10, -20, 30, -40, 1'b1);
        send_row(0, 0, 0, 1, 1'b0);
        send_row(0, 1, 0, 0, 1'b0);
        send_row(-5, 6, -7, 0, 1'b0);
        @(negedge clk);

        // Reset in the middle of a tile.
        send_row(3, 0, 0, 0, 1'b0);
        send_row(0, 0, 4, 0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_prune_err", 32'(prune_err), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check_tile_zero("mid_rst_tile");
`ifdef SPARSE_ENC_STATS_EN
        check("mid_rst_pruned_rows", 32'(pruned_rows), 32'd0);
`endif
        rows_q.delete();
        exp_err = 1'b0;
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        send_row(11, 0, 0, 0, 1'b0);
        send_row(0, 12, 0, 0, 1'b0);
        send_row(0, 0, 13, 0, 1'b0);
        send_row(0, 0, 0, 14, 1'b0);
        @(negedge clk);

        // Randomised rows with random backpressure and occasional clears.
        rand_ready = 1'b1;
        for (int r = 0; r < 160; r++) begin
            int density = $urandom_range(0, 3);
            for (int i = 0; i < 4; i++) begin
                w[i] = ($urandom_range(0, 3) < density) ? (int'($urandom_range(0, 255)) - 128) : 0;
            end
            send_row(w[0], w[1], w[2], w[3], ($urandom_range(0, 9) == 0));
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);

`ifdef SPARSE_ENC_STATS_EN
        // Counter saturation and clear.
        for (int r = 0; r < 65540; r++) send_row(1, 2, 3, 4, 1'b0);
        check("sat_pruned_rows", 32'(pruned_rows), 32'h0000FFFF);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("sat_clr_prune_err", 32'(prune_err), 32'd0);
        check("sat_clr_pruned_rows", 32'(pruned_rows), 32'd0);
`endif

        @(negedge clk);
        @(negedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sparse_weight_encoder
